// File: rtl/run_controller.sv
// Run sequencer for the core array: arms a run, drives core status, gathers sticky
// done flags, counts RUN cycles, enforces a watchdog and raises end_process after a drain.
// Optional per-core completion timestamps (core_cycles) when RUN_CTRL_PERCORE_CYCLES_EN is defined.
module run_controller #(
    parameter int unsigned     NUM_CORES      = 4,
    parameter int unsigned     CNT_W          = 32,
    parameter longint unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned     DRAIN_CYCLES   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_CORES-1:0]       core_en,
    input  logic [NUM_CORES-1:0]       core_done,
    output logic [1:0]                 status,
    output logic                       end_process,
    output logic                       timeout,
    output logic [NUM_CORES-1:0]       done_mask,
    output logic [CNT_W-1:0]           cycle_count,
`ifdef RUN_CTRL_PERCORE_CYCLES_EN
    output logic [NUM_CORES*CNT_W-1:0] core_cycles,
`endif
    output logic [2:0]                 state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] ST_HOLD = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    // A limit the counter can never reach (it saturates) leaves the watchdog inert.
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0) && (TIMEOUT_CYCLES <= CNT_MAX);
    localparam logic [31:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? 32'd0 : 32'(DRAIN_CYCLES - 1);

    state_t               state_q;
    logic [1:0]           status_q;
    logic                 end_q;
    logic                 timeout_q;
    logic [NUM_CORES-1:0] done_mask_q;
    logic [NUM_CORES-1:0] done_mask_d;
    logic [NUM_CORES-1:0] en_q;
    logic [CNT_W-1:0]     cycle_count_q;
    logic [CNT_W-1:0]     cycle_count_d;
    logic [31:0]          drain_cnt_q;
    logic                 all_done;
    logic                 wd_hit;

    // Handshake: start is a one-cycle request honoured only in IDLE or DONE; core_done
    // is level or pulse, qualified by the enable mask latched in ARM and by the RUN state.
    assign done_mask_d   = done_mask_q | (core_done & en_q);
    assign all_done      = (done_mask_d == en_q);
    assign cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;
    assign wd_hit        = WD_EN && ((64'(cycle_count_q) + 64'd1) == TIMEOUT_CYCLES);

`ifdef RUN_CTRL_PERCORE_CYCLES_EN
    logic [NUM_CORES*CNT_W-1:0] core_cycles_q;
    logic [NUM_CORES-1:0]       first_done;

    assign first_done  = core_done & en_q & ~done_mask_q;
    assign core_cycles = core_cycles_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            status_q      <= ST_HOLD;
            end_q         <= 1'b0;
            timeout_q     <= 1'b0;
            done_mask_q   <= '0;
            en_q          <= '0;
            cycle_count_q <= '0;
            drain_cnt_q   <= '0;
`ifdef RUN_CTRL_PERCORE_CYCLES_EN
            core_cycles_q <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q       <= S_ARM;
                        status_q      <= ST_HOLD;
                        end_q         <= 1'b0;
                        timeout_q     <= 1'b0;
                        done_mask_q   <= '0;
                        cycle_count_q <= '0;
`ifdef RUN_CTRL_PERCORE_CYCLES_EN
                        core_cycles_q <= '0;
`endif
                    end
                end
                S_ARM: begin
                    en_q     <= core_en;
                    state_q  <= S_RUN;
                    status_q <= ST_RUN;
                end
                S_RUN: begin
                    done_mask_q   <= done_mask_d;
                    cycle_count_q <= cycle_count_d;
`ifdef RUN_CTRL_PERCORE_CYCLES_EN
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (first_done[i]) begin
                            core_cycles_q[i*CNT_W +: CNT_W] <= cycle_count_d;
                        end
                    end
`endif
                    // Completion is checked first so a same-cycle tie never reports a timeout.
                    if (all_done) begin
                        state_q     <= S_DRAIN;
                        status_q    <= ST_HALT;
                        drain_cnt_q <= '0;
                    end else if (wd_hit) begin
                        state_q   <= S_DONE;
                        status_q  <= ST_HALT;
                        timeout_q <= 1'b1;
                        end_q     <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q >= DRAIN_LAST) begin
                        state_q <= S_DONE;
                        end_q   <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    status_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign status      = status_q;
    assign end_process = end_q;
    assign timeout     = timeout_q;
    assign done_mask   = done_mask_q;
    assign cycle_count = cycle_count_q;
    assign state_dbg   = state_q;

endmodule
